// File: rtl/md5_msg_padder.sv
// rtl/md5_msg_padder.sv - streaming MD5 padder: byte stream in, padded 512-bit blocks out
// Optional soft clear port clear_i enabled by defining MD5_PADDER_CLEAR_EN.
module md5_msg_padder #(
    parameter int LEN_BITS = 64
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         msg_valid_i,
    output logic         msg_ready_o,
    input  logic [7:0]   msg_byte_i,
    input  logic         msg_last_i,
    input  logic         msg_empty_i,
    output logic         blk_valid_o,
    input  logic         blk_ready_i,
    output logic [511:0] blk_data_o,
    output logic         blk_first_o,
    output logic         blk_last_o
`ifdef MD5_PADDER_CLEAR_EN
    ,
    input  logic         clear_i
`endif
);

    typedef enum logic [1:0] {FILL, PAD, LEN, EMIT} state_t;

    state_t              state;
    logic [7:0]          data_q [64];
    logic [5:0]          idx;
    logic [LEN_BITS-1:0] bitlen;
    logic                first_pend;
    logic                pad_pend;
    logic                len_pend;
    logic [63:0]         len64;
    logic                clr;

`ifdef MD5_PADDER_CLEAR_EN
    assign clr = clear_i;
`else
    assign clr = 1'b0;
`endif

    assign len64 = 64'(bitlen);

    // The block buffer is the output register; it is never written while in EMIT.
    for (genvar k = 0; k < 64; k++) begin : g_out
        assign blk_data_o[511-8*k -: 8] = data_q[k];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= FILL;
            idx         <= '0;
            bitlen      <= '0;
            first_pend  <= 1'b1;
            pad_pend    <= 1'b0;
            len_pend    <= 1'b0;
            msg_ready_o <= 1'b1;
            blk_valid_o <= 1'b0;
            blk_first_o <= 1'b0;
            blk_last_o  <= 1'b0;
            for (int k = 0; k < 64; k++) data_q[k] <= 8'h00;
        end else if (clr) begin
            state       <= FILL;
            idx         <= '0;
            bitlen      <= '0;
            first_pend  <= 1'b1;
            pad_pend    <= 1'b0;
            len_pend    <= 1'b0;
            msg_ready_o <= 1'b1;
            blk_valid_o <= 1'b0;
            blk_first_o <= 1'b0;
            blk_last_o  <= 1'b0;
            for (int k = 0; k < 64; k++) data_q[k] <= 8'h00;
        end else begin
            case (state)
                FILL: begin
                    if (msg_valid_i) begin
                        if (!msg_empty_i) begin
                            data_q[idx] <= msg_byte_i;
                            idx         <= idx + 6'd1;
                            bitlen      <= bitlen + LEN_BITS'(8);
                        end
                        if (!msg_empty_i && idx == 6'd63) begin
                            state       <= EMIT;
                            msg_ready_o <= 1'b0;
                            blk_valid_o <= 1'b1;
                            blk_first_o <= first_pend;
                            blk_last_o  <= 1'b0;
                            pad_pend    <= msg_last_i;
                        end else if (msg_last_i) begin
                            state       <= PAD;
                            msg_ready_o <= 1'b0;
                        end
                    end
                end
                PAD: begin
                    for (int k = 0; k < 64; k++) begin
                        if (k == int'(idx))
                            data_q[k] <= 8'h80;
                        else if (k > int'(idx))
                            data_q[k] <= 8'h00;
                    end
                    // Length fits behind the 0x80 only if it still leaves bytes 56..63 free.
                    if (idx <= 6'd55) begin
                        for (int j = 0; j < 8; j++) data_q[56+j] <= len64[8*j +: 8];
                        blk_last_o <= 1'b1;
                        len_pend   <= 1'b0;
                    end else begin
                        blk_last_o <= 1'b0;
                        len_pend   <= 1'b1;
                    end
                    state       <= EMIT;
                    blk_valid_o <= 1'b1;
                    blk_first_o <= first_pend;
                end
                LEN: begin
                    for (int k = 0; k < 56; k++) data_q[k] <= 8'h00;
                    for (int j = 0; j < 8; j++) data_q[56+j] <= len64[8*j +: 8];
                    state       <= EMIT;
                    blk_valid_o <= 1'b1;
                    blk_first_o <= first_pend;
                    blk_last_o  <= 1'b1;
                end
                EMIT: begin
                    if (blk_ready_i) begin
                        blk_valid_o <= 1'b0;
                        idx         <= '0;
                        first_pend  <= 1'b0;
                        if (pad_pend) begin
                            state    <= PAD;
                            pad_pend <= 1'b0;
                        end else if (len_pend) begin
                            state    <= LEN;
                            len_pend <= 1'b0;
                        end else begin
                            state       <= FILL;
                            msg_ready_o <= 1'b1;
                            if (blk_last_o) begin
                                bitlen     <= '0;
                                first_pend <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_md5_msg_padder.sv
// tb/tb_md5_msg_padder.sv - randomized self-checking bench for md5_msg_padder
module tb_md5_msg_padder;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         msg_valid_i;
    logic         msg_ready_o;
    logic [7:0]   msg_byte_i;
    logic         msg_last_i;
    logic         msg_empty_i;
    logic         blk_valid_o;
    logic         blk_ready_i;
    logic [511:0] blk_data_o;
    logic         blk_first_o;
    logic         blk_last_o;
`ifdef MD5_PADDER_CLEAR_EN
    logic         clear_i;
`endif

    always #5 clk = ~clk;

    md5_msg_padder #(.LEN_BITS(64)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .msg_valid_i (msg_valid_i),
        .msg_ready_o (msg_ready_o),
        .msg_byte_i  (msg_byte_i),
        .msg_last_i  (msg_last_i),
        .msg_empty_i (msg_empty_i),
        .blk_valid_o (blk_valid_o),
        .blk_ready_i (blk_ready_i),
        .blk_data_o  (blk_data_o),
        .blk_first_o (blk_first_o),
        .blk_last_o  (blk_last_o)
`ifdef MD5_PADDER_CLEAR_EN
        ,
        .clear_i     (clear_i)
`endif
    );

    typedef logic [7:0] bq_t [$];
    typedef struct {
        logic [511:0] d;
        logic         f;
        logic         l;
    } blk_t;

    int   vectors = 0;
    int   miscompares = 0;
    bit   hold = 1'b0;
    blk_t exp_q [$];

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: append 0x80, zero-fill to 56 mod 64, append 64-bit LE bit count, cut into blocks.
    function automatic void build_expected(input bq_t m);
        bq_t         p;
        logic [63:0] len;
        blk_t        b;
        int          nb;
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        len = 64'(m.size()) * 64'd8;
        for (int j = 0; j < 8; j++) p.push_back(len[8*j +: 8]);
        nb = p.size() / 64;
        for (int bi = 0; bi < nb; bi++) begin
            for (int k = 0; k < 64; k++) b.d[511-8*k -: 8] = p[bi*64+k];
            b.f = (bi == 0);
            b.l = (bi == nb - 1);
            exp_q.push_back(b);
        end
    endfunction

    function automatic bq_t rand_msg(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    task automatic wait_ready();
        int g = 0;
        while (!msg_ready_o && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (!msg_ready_o) begin
            miscompares++;
            $display("FAIL rdy_timeout got=0 exp=1");
        end
    endtask

    task automatic send_msg(input bq_t m);
        int beats;
        beats = (m.size() == 0) ? 1 : m.size();
        @(negedge clk);
        for (int i = 0; i < beats; i++) begin
            msg_valid_i = 1'b1;
            msg_last_i  = (i == beats - 1);
            msg_empty_i = (m.size() == 0);
            msg_byte_i  = (m.size() == 0) ? 8'h00 : m[i];
            wait_ready();
            @(posedge clk);
            @(negedge clk);
            if (m.size() != 0 && i % 64 == 63) begin
                check("full_blk_rise", 512'(blk_valid_o), 512'(1));
            end else if (msg_last_i) begin
                msg_valid_i = 1'b0;
                check("pad_bubble", 512'({blk_valid_o, msg_ready_o}), 512'(0));
                @(negedge clk);
                check("final_rise", 512'(blk_valid_o), 512'(1));
            end
            if (!msg_last_i && $urandom_range(0, 3) == 0) begin
                msg_valid_i = 1'b0;
                @(negedge clk);
            end
        end
        msg_valid_i = 1'b0;
        msg_last_i  = 1'b0;
        msg_empty_i = 1'b0;
    endtask

    task automatic collect();
        int g = 0;
        while (exp_q.size() > 0 && g < 8000) begin
            @(negedge clk);
            g++;
            blk_ready_i = hold ? 1'b0 : 1'($urandom_range(0, 1));
            if (blk_valid_o) begin
                check("blk_data", blk_data_o, exp_q[0].d);
                check("blk_first", 512'(blk_first_o), 512'(exp_q[0].f));
                check("blk_last", 512'(blk_last_o), 512'(exp_q[0].l));
                check("ready_in_emit", 512'(msg_ready_o), 512'(0));
                if (blk_ready_i) void'(exp_q.pop_front());
            end
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL blk_timeout got=%0d exp=0 blocks outstanding", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1 blk_ready_i = 1'b0;
    endtask

    task automatic run_msg(input bq_t m);
        build_expected(m);
        fork
            send_msg(m);
            collect();
        join
    endtask

    task automatic feed_raw(input int n);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            msg_valid_i = 1'b1;
            msg_last_i  = 1'b0;
            msg_empty_i = 1'b0;
            msg_byte_i  = 8'($urandom_range(0, 255));
            wait_ready();
            @(posedge clk);
            @(negedge clk);
        end
        msg_valid_i = 1'b0;
    endtask

    initial begin
        bq_t m;
        rst_ni      = 1'b0;
        msg_valid_i = 1'b0;
        msg_byte_i  = 8'h00;
        msg_last_i  = 1'b0;
        msg_empty_i = 1'b0;
        blk_ready_i = 1'b0;
`ifdef MD5_PADDER_CLEAR_EN
        clear_i     = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_msg_ready", 512'(msg_ready_o), 512'(1));
        check("rst_blk_valid", 512'(blk_valid_o), 512'(0));
        check("rst_blk_data", blk_data_o, 512'(0));
        check("rst_blk_first", 512'(blk_first_o), 512'(0));
        check("rst_blk_last", 512'(blk_last_o), 512'(0));
        rst_ni = 1'b1;

        m = {};
        run_msg(m);
        m = {8'h61, 8'h62, 8'h63};
        run_msg(m);
        run_msg(rand_msg(55));
        run_msg(rand_msg(56));
        run_msg(rand_msg(63));
        run_msg(rand_msg(64));
        run_msg(rand_msg(119));
        run_msg(rand_msg(128));
        for (int r = 0; r < 20; r++) run_msg(rand_msg($urandom_range(0, 200)));

        // Back-pressure: block held for 10 cycles with the core not ready.
        m = rand_msg(10);
        build_expected(m);
        fork
            send_msg(m);
            collect();
            begin
                int g = 0;
                hold = 1'b1;
                while (!blk_valid_o && g < 200) begin
                    @(negedge clk);
                    g++;
                end
                repeat (10) @(negedge clk);
                hold = 1'b0;
            end
        join

`ifdef MD5_PADDER_CLEAR_EN
        feed_raw(20);
        clear_i     = 1'b1;
        msg_valid_i = 1'b1;
        msg_byte_i  = 8'h5a;
        @(negedge clk);
        clear_i     = 1'b0;
        msg_valid_i = 1'b0;
        check("clr_msg_ready", 512'(msg_ready_o), 512'(1));
        check("clr_blk_valid", 512'(blk_valid_o), 512'(0));
        run_msg(rand_msg(30));
`endif

        // Asynchronous reset while a full data block waits in EMIT.
        feed_raw(64);
        check("pre_rst_valid", 512'(blk_valid_o), 512'(1));
        repeat (2) @(negedge clk);
        #3 rst_ni = 1'b0;
        #1;
        check("async_rst_valid", 512'(blk_valid_o), 512'(0));
        check("async_rst_ready", 512'(msg_ready_o), 512'(1));
        check("async_rst_data", blk_data_o, 512'(0));
        @(negedge clk);
        rst_ni = 1'b1;
        m = {8'h61, 8'h62, 8'h63};
        run_msg(m);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
